// File: rtl/semaforo_monitor_seguranca.sv
// Safety monitor for the two-approach intersection: synchronises the lamp outputs, checks the
// intersection rules, latches the first fault code and requests a flashing-yellow override.
// Optional fault counter port enabled by defining MONITOR_FAULT_COUNT_EN.
module semaforo_monitor_seguranca #(
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned MAX_PHASE  = 20,
  parameter int unsigned LAMP_TOL   = 1,
  parameter int unsigned FLASH_HALF = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       light_A_GREEN,
  input  logic       light_A_YELLOW,
  input  logic       light_A_RED,
  input  logic       light_B_GREEN,
  input  logic       light_B_YELLOW,
  input  logic       light_B_RED,
  input  logic       p_light_A_GREEN,
  input  logic       p_light_A_RED,
  input  logic       p_light_B_GREEN,
  input  logic       p_light_B_RED,
  input  logic       clear_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_out
`ifdef MONITOR_FAULT_COUNT_EN
  ,
  output logic [7:0] fault_count
`endif
);

  localparam logic [2:0] ST_UNKNOWN = 3'd0;
  localparam logic [2:0] ST_G       = 3'd1;
  localparam logic [2:0] ST_Y       = 3'd2;
  localparam logic [2:0] ST_R       = 3'd3;
  localparam logic [2:0] ST_INVALID = 3'd4;

  localparam logic [CNT_W-1:0] MIN_YELLOW_C = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAX_PHASE_C  = CNT_W'(MAX_PHASE);
  localparam logic [CNT_W-1:0] LAMP_TOL_C   = CNT_W'(LAMP_TOL);
  localparam logic [CNT_W-1:0] FLASH_LAST_C = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + ONE_C;
  endfunction

  function automatic logic [2:0] decode(input logic [2:0] gyr);
    case (gyr)
      3'b100:  return ST_G;
      3'b010:  return ST_Y;
      3'b001:  return ST_R;
      default: return ST_INVALID;
    endcase
  endfunction

  function automatic logic is_valid(input logic [2:0] st);
    return (st == ST_G) || (st == ST_Y) || (st == ST_R);
  endfunction

  function automatic logic seq_bad(input logic [2:0] prv, input logic [2:0] cur);
    return is_valid(prv) && is_valid(cur) &&
           (((prv == ST_G) && (cur == ST_R)) ||
            ((prv == ST_Y) && (cur == ST_G)) ||
            ((prv == ST_R) && (cur == ST_Y)));
  endfunction

  logic [9:0]            lamps_raw;
  logic [9:0]            sync1_q, sync2_q;
  logic [1:0]            vld_q;
  logic [1:0][2:0]       st_cur;
  logic [1:0][2:0]       prev_q, prev_d;
  logic [1:0][CNT_W-1:0] yel_q, yel_d;
  logic [1:0][CNT_W-1:0] inv_q, inv_d;
  logic [5:0]            car_vec, vec_q, vec_d;
  logic [CNT_W-1:0]      run_q, run_d, run_now;
  logic [CNT_W-1:0]      fcnt_q, fcnt_d;
  logic                  fault_q, fault_d;
  logic [2:0]            code_q, code_d;
  logic                  flash_q, flash_d;
  logic                  v_conf, v_inv, v_ped, v_pinv, v_seq, v_short, v_wd;
  logic [2:0]            code_now;
  logic                  clr_ok;

  assign lamps_raw = {light_A_GREEN, light_A_YELLOW, light_A_RED,
                      light_B_GREEN, light_B_YELLOW, light_B_RED,
                      p_light_A_GREEN, p_light_A_RED, p_light_B_GREEN, p_light_B_RED};

  assign car_vec   = sync2_q[9:4];
  assign st_cur[0] = decode(sync2_q[9:7]);
  assign st_cur[1] = decode(sync2_q[6:4]);

  always_comb begin
    prev_d  = prev_q;
    yel_d   = yel_q;
    inv_d   = inv_q;
    vec_d   = vec_q;
    run_d   = run_q;
    v_inv   = 1'b0;
    v_seq   = 1'b0;
    v_short = 1'b0;
    run_now = ((car_vec == vec_q) && (run_q != '0)) ? sat_inc(run_q) : ONE_C;

    // vld_q marks synchronizer stages holding real samples, so reset zeros never look INVALID
    if (vld_q[1]) begin
      for (int unsigned i = 0; i < 2; i++) begin
        if ((st_cur[i] == ST_INVALID) && (inv_q[i] >= LAMP_TOL_C)) v_inv = 1'b1;
        if (seq_bad(prev_q[i], st_cur[i])) v_seq = 1'b1;
        if ((prev_q[i] == ST_Y) && (st_cur[i] == ST_R) && (yel_q[i] < MIN_YELLOW_C)) v_short = 1'b1;
        prev_d[i] = st_cur[i];
        yel_d[i]  = (st_cur[i] == ST_Y)       ? sat_inc(yel_q[i]) : '0;
        inv_d[i]  = (st_cur[i] == ST_INVALID) ? sat_inc(inv_q[i]) : '0;
      end
      vec_d = car_vec;
      run_d = run_now;
    end

    v_conf = vld_q[1] && (sync2_q[9] || sync2_q[8]) && (sync2_q[6] || sync2_q[5]);
    v_ped  = vld_q[1] && ((!sync2_q[2] && !sync2_q[7]) || (!sync2_q[0] && !sync2_q[4]));
    v_pinv = vld_q[1] && ((sync2_q[3] && sync2_q[2]) || (sync2_q[1] && sync2_q[0]));
    v_wd   = vld_q[1] && (run_now >= MAX_PHASE_C);

    if      (v_conf)  code_now = 3'd1;
    else if (v_inv)   code_now = 3'd2;
    else if (v_ped)   code_now = 3'd3;
    else if (v_pinv)  code_now = 3'd4;
    else if (v_seq)   code_now = 3'd5;
    else if (v_short) code_now = 3'd6;
    else if (v_wd)    code_now = 3'd7;
    else              code_now = 3'd0;

    clr_ok  = clear_fault && (code_now == 3'd0);
    fault_d = fault_q;
    code_d  = code_q;
    flash_d = flash_q;
    fcnt_d  = fcnt_q;

    if (clr_ok) begin
      fault_d = 1'b0;
      code_d  = 3'd0;
      flash_d = 1'b0;
      fcnt_d  = '0;
      prev_d  = {2{ST_UNKNOWN}};
      yel_d   = '0;
      inv_d   = '0;
      run_d   = '0;
    end else if (!fault_q && (code_now != 3'd0)) begin
      fault_d = 1'b1;
      code_d  = code_now;
      flash_d = 1'b1;
      fcnt_d  = '0;
    end else if (fault_q) begin
      if (fcnt_q == FLASH_LAST_C) begin
        flash_d = ~flash_q;
        fcnt_d  = '0;
      end else begin
        fcnt_d  = fcnt_q + ONE_C;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vld_q   <= '0;
      prev_q  <= {2{ST_UNKNOWN}};
      yel_q   <= '0;
      inv_q   <= '0;
      vec_q   <= '0;
      run_q   <= '0;
      fcnt_q  <= '0;
      fault_q <= 1'b0;
      code_q  <= 3'd0;
      flash_q <= 1'b0;
    end else begin
      sync1_q <= lamps_raw;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      prev_q  <= prev_d;
      yel_q   <= yel_d;
      inv_q   <= inv_d;
      vec_q   <= vec_d;
      run_q   <= run_d;
      fcnt_q  <= fcnt_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      flash_q <= flash_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign flash_out  = flash_q;

`ifdef MONITOR_FAULT_COUNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!fault_q && fault_d && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign fault_count = cnt_q;
`endif

endmodule

// File: tb/tb_semaforo_monitor_seguranca.sv
// Directed bench for semaforo_monitor_seguranca: vector table for single-rule faults plus
// hand sequences for controller operation, sequencing, watchdog, clear, flash and reset.
module tb_semaforo_monitor_seguranca;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] lamps;
  logic       clear_fault = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_out;
`ifdef MONITOR_FAULT_COUNT_EN
  logic [7:0] fault_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // lamp word: {aG,aY,aR, bG,bY,bR, paG,paR, pbG,pbR}
  localparam logic [9:0] BASE     = 10'b100_001_01_01;
  localparam logic [9:0] CONFLICT = 10'b100_100_01_01;

  semaforo_monitor_seguranca #(
    .MIN_YELLOW(3), .MAX_PHASE(20), .LAMP_TOL(1), .FLASH_HALF(4), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .light_A_GREEN(lamps[9]), .light_A_YELLOW(lamps[8]), .light_A_RED(lamps[7]),
    .light_B_GREEN(lamps[6]), .light_B_YELLOW(lamps[5]), .light_B_RED(lamps[4]),
    .p_light_A_GREEN(lamps[3]), .p_light_A_RED(lamps[2]),
    .p_light_B_GREEN(lamps[1]), .p_light_B_RED(lamps[0]),
    .clear_fault(clear_fault),
    .fault(fault), .fault_code(fault_code), .flash_out(flash_out)
`ifdef MONITOR_FAULT_COUNT_EN
    , .fault_count(fault_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [9:0] lamps;
    int         ticks;
    logic [2:0] code;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [9:0] lv, input int post);
    reset = 1'b1;
    clear_fault = 1'b0;
    lamps = lv;
    tick();
    tick();
    reset = 1'b0;
    repeat (post) tick();
  endtask

  // reference controller: green 13, yellow 4, pedestrians walk/blink while their car approach is red
  function automatic logic [9:0] ctrl(input int t);
    logic aG, aY, aR, bG, bY, bR, paG, paR, pbG, pbR;
    aG  = (t < 13);
    aY  = (t >= 13) && (t < 17);
    aR  = (t >= 17);
    bR  = (t < 17);
    bG  = (t >= 17) && (t < 30);
    bY  = (t >= 30);
    paG = ((t >= 17) && (t < 26)) || ((t >= 26) && (t % 2 == 1));
    paR = (t < 17);
    pbG = (t < 9) || ((t >= 9) && (t < 17) && (t % 2 == 1));
    pbR = (t >= 17);
    return {aG, aY, aR, bG, bY, bR, paG, paR, pbG, pbR};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1 (simulation did not finish)");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[10];
    tbl[0] = '{"legal_ped_walk", 10'b100_001_01_10, 4, 3'd0};
    tbl[1] = '{"conflict_gg",    10'b100_100_01_01, 3, 3'd1};
    tbl[2] = '{"conflict_gy",    10'b100_010_01_01, 3, 3'd1};
    tbl[3] = '{"a_dark",         10'b000_001_01_01, 4, 3'd2};
    tbl[4] = '{"a_gy_lit",       10'b110_001_01_01, 4, 3'd2};
    tbl[5] = '{"ped_a_dark",     10'b100_001_00_01, 3, 3'd3};
    tbl[6] = '{"ped_b_both",     10'b100_001_01_11, 3, 3'd4};
    tbl[7] = '{"prio_conf_pinv", 10'b100_100_11_01, 3, 3'd1};
    tbl[8] = '{"prio_ped_pinv",  10'b100_001_00_11, 3, 3'd3};
    tbl[9] = '{"b_dark",         10'b100_000_01_01, 4, 3'd2};

    lamps = BASE;
    #2;
    chk("reset_fault", {7'd0, fault}, 8'd0);
    chk("reset_code", {5'd0, fault_code}, 8'd0);
    chk("reset_flash", {7'd0, flash_out}, 8'd0);

    for (int i = 0; i < 10; i++) begin
      do_reset(BASE, 3);
      lamps = tbl[i].lamps;
      repeat (tbl[i].ticks - 1) tick();
      chk({tbl[i].name, "_early"}, {7'd0, fault}, 8'd0);
      tick();
      chk({tbl[i].name, "_fault"}, {7'd0, fault}, {7'd0, tbl[i].code != 3'd0});
      chk({tbl[i].name, "_code"}, {5'd0, fault_code}, {5'd0, tbl[i].code});
    end

    // 1: three full controller cycles stay clean
    do_reset(ctrl(0), 3);
    for (int c = 0; c < 102; c++) begin
      lamps = ctrl(c % 34);
      tick();
      chk("ctrl_clean", {3'd0, fault, fault_code, flash_out}, 8'd0);
    end

    // 1-cycle invalid glitch is tolerated
    do_reset(BASE, 3);
    lamps = 10'b000_001_01_01;
    tick();
    lamps = BASE;
    repeat (5) tick();
    chk("glitch_tolerated", {7'd0, fault}, 8'd0);

    // 2: conflict injected at cycle 10, then flash cadence
    do_reset(ctrl(0), 3);
    for (int c = 0; c < 10; c++) begin
      lamps = ctrl(c);
      tick();
    end
    lamps = CONFLICT;
    tick();
    tick();
    chk("conf_latency", {7'd0, fault}, 8'd0);
    tick();
    chk("conf_fault", {7'd0, fault}, 8'd1);
    chk("conf_code", {5'd0, fault_code}, 8'd1);
    for (int k = 0; k < 13; k++) begin
      chk("flash_cadence", {7'd0, flash_out}, {7'd0, ((k / 4) % 2) == 0});
      tick();
    end

    // 3: legal 3-cycle yellow, then 2-cycle yellow, then G->R on B must not overwrite
    do_reset(BASE, 3);
    lamps = 10'b010_001_01_01;
    repeat (3) tick();
    lamps = 10'b001_001_01_01;
    repeat (4) tick();
    chk("yellow3_ok", {7'd0, fault}, 8'd0);
    lamps = BASE;
    repeat (3) tick();
    lamps = 10'b010_001_01_01;
    repeat (2) tick();
    lamps = 10'b001_001_01_01;
    tick();
    tick();
    chk("short_y_latency", {7'd0, fault}, 8'd0);
    tick();
    chk("short_y_code", {5'd0, fault_code}, 8'd6);
    lamps = 10'b001_100_01_01;
    repeat (4) tick();
    lamps = 10'b001_001_01_01;
    repeat (4) tick();
    chk("first_kept_fault", {7'd0, fault}, 8'd1);
    chk("first_kept_code", {5'd0, fault_code}, 8'd6);

    // 4: direct G->R
    do_reset(BASE, 3);
    lamps = 10'b001_001_01_01;
    tick();
    tick();
    chk("seq_latency", {7'd0, fault}, 8'd0);
    tick();
    chk("seq_code", {5'd0, fault_code}, 8'd5);

    // 4b: watchdog on a car vector held from reset release
    do_reset(BASE, 0);
    repeat (21) tick();
    chk("wd_early", {7'd0, fault}, 8'd0);
    tick();
    chk("wd_fault", {7'd0, fault}, 8'd1);
    chk("wd_code", {5'd0, fault_code}, 8'd7);

    // 5: priority, clear rejected while violating, clear accepted afterwards
    do_reset(BASE, 3);
    lamps = 10'b100_100_11_01;
    repeat (3) tick();
    chk("prio_code", {5'd0, fault_code}, 8'd1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("clr_rejected_fault", {7'd0, fault}, 8'd1);
    chk("clr_rejected_code", {5'd0, fault_code}, 8'd1);
    lamps = BASE;
    repeat (4) tick();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("clr_ok_outputs", {3'd0, fault, fault_code, flash_out}, 8'd0);
    repeat (4) tick();
    chk("clr_stays_clean", {7'd0, fault}, 8'd0);

    // 6: async reset mid-flash
    do_reset(BASE, 3);
    lamps = CONFLICT;
    repeat (5) tick();
    chk("pre_rst_fault", {7'd0, fault}, 8'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_outputs", {3'd0, fault, fault_code, flash_out}, 8'd0);

`ifdef MONITOR_FAULT_COUNT_EN
    do_reset(BASE, 3);
    for (int n = 0; n < 3; n++) begin
      lamps = CONFLICT;
      repeat (3) tick();
      lamps = BASE;
      repeat (4) tick();
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      tick();
    end
    chk("fault_count_3", fault_count, 8'd3);
    chk("fault_count_cleared_flag", {7'd0, fault}, 8'd0);
    reset = 1'b1;
    #1;
    chk("fault_count_rst", fault_count, 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
